// File: rtl/lab6_apb_slv_if.sv
// lab6_apb_slv_if : APB slave front end for the add/delay function block.
// Holds operands A/B, launches a calculation on START, captures the
// function block's registered sum and exposes BUSY/DONE/RESULT/COUNT.
// RESULT reads during a calculation are stretched with wait states.
// Optional feature macro: LAB6_APB_IRQ_EN (registered done interrupt on oIrq).
module lab6_apb_slv_if #(
  parameter int P_CNT_W = 16
) (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iPsel,
  input  logic        iPenable,
  input  logic        iPwrite,
  input  logic [7:0]  iPaddr,
  input  logic [31:0] iPwdata,
  output logic [31:0] oPrdata,
  output logic        oPready,
  output logic        oPslverr,
  output logic [31:0] oInA,
  output logic [31:0] oInB,
  input  logic [31:0] iOutC,
  output logic        oIrq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  localparam logic [5:0] IDX_A      = 6'd0;
  localparam logic [5:0] IDX_B      = 6'd1;
  localparam logic [5:0] IDX_CTRL   = 6'd2;
  localparam logic [5:0] IDX_STATUS = 6'd3;
  localparam logic [5:0] IDX_RESULT = 6'd4;
  localparam logic [5:0] IDX_COUNT  = 6'd5;

  state_t               state_r;
  state_t               state_s;
  logic [31:0]          a_r;
  logic [31:0]          b_r;
  logic [31:0]          result_r;
  logic [P_CNT_W-1:0]   count_r;
  logic                 done_r;

  logic [5:0]           idx_s;
  logic                 access_s;
  logic                 busy_s;
  logic                 rd_wait_s;
  logic                 complete_s;
  logic                 addr_ok_s;
  logic                 wr_s;
  logic                 wr_a_s;
  logic                 wr_b_s;
  logic                 ctrl_wr_s;
  logic                 start_s;
  logic                 clr_s;
  logic                 capture_s;
  logic                 busy_block_s;
  logic [31:0]          rd_mux_s;
  logic                 unused_addr_s;

  // Byte-offset bits are not part of the register index.
  assign unused_addr_s = ^iPaddr[1:0];

  assign idx_s      = iPaddr[7:2];
  assign access_s   = iPsel & iPenable;
  assign busy_s     = (state_r != ST_IDLE);
  // A RESULT read must not complete until the pending sum has been captured.
  assign rd_wait_s  = access_s & ~iPwrite & (idx_s == IDX_RESULT) & busy_s;
  assign complete_s = access_s & ~rd_wait_s;
  assign oPready    = ~rd_wait_s;
  assign capture_s  = (state_r == ST_CAPT);

  // Writes that would disturb an in-flight calculation are rejected.
  assign busy_block_s = busy_s & ((idx_s == IDX_A) | (idx_s == IDX_B) |
                                  ((idx_s == IDX_CTRL) & iPwdata[0]));

  assign wr_s      = complete_s & iPwrite & addr_ok_s;
  assign wr_a_s    = wr_s & (idx_s == IDX_A) & ~busy_s;
  assign wr_b_s    = wr_s & (idx_s == IDX_B) & ~busy_s;
  assign ctrl_wr_s = wr_s & (idx_s == IDX_CTRL);
  assign start_s   = ctrl_wr_s & iPwdata[0] & ~busy_s;
  // A CTRL write carrying START while busy is dropped as a whole.
  assign clr_s     = ctrl_wr_s & iPwdata[1] & ~busy_block_s;

  assign oInA = a_r;
  assign oInB = b_r;

  // Address decode: flag indices that map to a real register.
  always_comb begin
    addr_ok_s = 1'b0;
    case (idx_s)
      IDX_A, IDX_B, IDX_CTRL, IDX_STATUS, IDX_RESULT, IDX_COUNT: addr_ok_s = 1'b1;
      default: addr_ok_s = 1'b0;
    endcase
  end

  // Read data multiplexer over the register map.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      IDX_A:      rd_mux_s = a_r;
      IDX_B:      rd_mux_s = b_r;
      IDX_CTRL:   rd_mux_s = 32'd0;
      IDX_STATUS: rd_mux_s = {30'd0, done_r, busy_s};
      IDX_RESULT: rd_mux_s = result_r;
      IDX_COUNT:  rd_mux_s = 32'(count_r);
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // APB response: data and error only in the completing access cycle, forced low in reset.
  always_comb begin
    oPrdata  = 32'd0;
    oPslverr = 1'b0;
    if (iRsn && complete_s) begin
      if (!addr_ok_s) begin
        oPslverr = 1'b1;
      end else if (iPwrite) begin
        oPslverr = busy_block_s;
      end else begin
        oPrdata = rd_mux_s;
      end
    end else begin
      oPrdata  = 32'd0;
      oPslverr = 1'b0;
    end
  end

  // Next-state logic: START launches, then one CALC and one CAPT cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: state_s = ST_CAPT;
      ST_CAPT: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand registers, writable only while idle.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      a_r <= 32'd0;
      b_r <= 32'd0;
    end else begin
      if (wr_a_s) begin
        a_r <= iPwdata;
      end
      if (wr_b_s) begin
        b_r <= iPwdata;
      end
    end
  end

  // Result capture and completed-operation counter (wraps naturally).
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      result_r <= 32'd0;
      count_r  <= '0;
    end else if (capture_s) begin
      result_r <= iOutC;
      count_r  <= count_r + P_CNT_W'(1);
    end else begin
      result_r <= result_r;
      count_r  <= count_r;
    end
  end

  // DONE flag: a capture wins over a DONE_CLR landing on the same edge.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      done_r <= 1'b0;
    end else if (capture_s) begin
      done_r <= 1'b1;
    end else if (clr_s || start_s) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_r;
    end
  end

`ifdef LAB6_APB_IRQ_EN
  logic irq_r;

  // Interrupt register with the same set/clear rules as DONE.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      irq_r <= 1'b0;
    end else if (capture_s) begin
      irq_r <= 1'b1;
    end else if (clr_s || start_s) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign oIrq = irq_r;
`else
  assign oIrq = 1'b0;
`endif

endmodule

// File: tb/tb_lab6_apb_slv_if.sv
// Testbench for lab6_apb_slv_if: directed plan items plus random APB traffic,
// checked by a scoreboard against a transaction-level reference model.
module tb_lab6_apb_slv_if;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata, ina, inb, out_c;
  logic        pready, pslverr, irq;
  logic [31:0] prdata2, ina2, inb2;
  logic        pready2, pslverr2, irq2;

  int n_chk = 0;
  int n_fail = 0;

  lab6_apb_slv_if dut (
    .iClk(clk), .iRsn(rsn), .iPsel(psel), .iPenable(penable), .iPwrite(pwrite),
    .iPaddr(paddr), .iPwdata(pwdata), .oPrdata(prdata), .oPready(pready),
    .oPslverr(pslverr), .oInA(ina), .oInB(inb), .iOutC(out_c), .oIrq(irq)
  );

  lab6_apb_slv_if #(.P_CNT_W(2)) dut_w2 (
    .iClk(clk), .iRsn(rsn), .iPsel(psel), .iPenable(penable), .iPwrite(pwrite),
    .iPaddr(paddr), .iPwdata(pwdata), .oPrdata(prdata2), .oPready(pready2),
    .oPslverr(pslverr2), .oInA(ina2), .oInB(inb2), .iOutC(out_c), .oIrq(irq2)
  );

  always #5 clk = ~clk;

  // Function block stand-in: registered A+B, one clock of latency.
  always @(posedge clk) out_c <= ina + inb;

  // Reference model state (transaction level).
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0, m_pend = 32'd0;
  bit          m_done = 1'b0;
  int          m_busy_left = 0;
  int unsigned m_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] rdata2;
    logic        slverr;
    int          waits;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_irq();
`ifdef LAB6_APB_IRQ_EN
    return m_done;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_pend = 32'd0;
    m_done = 1'b0; m_busy_left = 0; m_cnt = 0;
  endtask

  // Advance one clock; fin marks the edge at which the current transfer completes.
  task automatic tick(input bit fin, input bit w, input logic [7:0] a, input logic [31:0] d);
    int bl;
    int idx;
    bl = m_busy_left;
    idx = int'(a[7:2]);
    @(posedge clk);
    if (m_busy_left > 0) m_busy_left--;
    if (fin && w && idx <= 5) begin
      case (idx)
        0: if (bl == 0) m_a = d;
        1: if (bl == 0) m_b = d;
        2: begin
          if (d[0]) begin
            if (bl == 0) begin
              m_done = 1'b0;
              m_pend = m_a + m_b;
              m_busy_left = 2;
            end
          end else if (d[1]) begin
            m_done = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (bl == 1) begin
      m_res = m_pend;
      m_done = 1'b1;
      m_cnt++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // One APB transfer; fast skips the setup phase (access right after previous access).
  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d, input bit fast);
    exp_t e;
    int   idx;
    bit   ok, busy;
    psel = 1'b1; pwrite = w; paddr = a; pwdata = d;
    if (!fast) begin
      penable = 1'b0;
      tick(1'b0, w, a, d);
    end
    penable = 1'b1;
    idx  = int'(a[7:2]);
    ok   = (idx <= 5);
    busy = (m_busy_left != 0);
    e.waits  = (!w && idx == 4 && busy) ? m_busy_left : 0;
    e.slverr = !ok || (w && busy && (idx == 0 || idx == 1 || (idx == 2 && d[0])));
    e.rdata  = 32'd0;
    e.rdata2 = 32'd0;
    if (!w && ok) begin
      case (idx)
        0: e.rdata = m_a;
        1: e.rdata = m_b;
        3: e.rdata = {30'd0, m_done, busy};
        4: e.rdata = busy ? m_pend : m_res;
        5: e.rdata = m_cnt & 32'h0000_FFFF;
        default: e.rdata = 32'd0;
      endcase
      e.rdata2 = (idx == 5) ? (m_cnt & 32'h0000_0003) : e.rdata;
    end
    sb_q.push_back(e);
    repeat (e.waits) tick(1'b0, w, a, d);
    tick(1'b1, w, a, d);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every completing access and checks idle-cycle outputs.
  int wcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rsn) begin
      wcnt = 0;
    end else begin
      if (psel && penable) begin
        if (!pready) begin
          wcnt++;
          if (wcnt > 4) chk("wait_bound", wcnt, 4);
        end else begin
          if (sb_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("prdata", prdata, e.rdata);
            chk("pslverr", {31'd0, pslverr}, {31'd0, e.slverr});
            chk("wait_states", wcnt, e.waits);
            chk("prdata_cntw2", prdata2, e.rdata2);
          end
          wcnt = 0;
        end
      end else begin
        chk("idle_prdata", prdata, 32'd0);
        chk("idle_pslverr", {31'd0, pslverr}, 32'd0);
        chk("idle_pready", {31'd0, pready}, 32'd1);
      end
      chk("inA", ina, m_a);
      chk("inB", inb, m_b);
      chk("irq", {31'd0, irq}, {31'd0, exp_irq()});
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    bit          w;
    int          sel;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd1);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_inA", ina, 32'd0);
    rsn = 1'b1;
    idle(2);
    apb(0, 8'h00, 32'd0, 0); apb(0, 8'h04, 32'd0, 0); apb(0, 8'h0C, 32'd0, 0);
    apb(0, 8'h10, 32'd0, 0); apb(0, 8'h14, 32'd0, 0);

    // Basic add with status polling
    apb(1, 8'h00, 32'h0000_0005, 0);
    apb(1, 8'h04, 32'h0000_0007, 0);
    apb(1, 8'h08, 32'h0000_0001, 0);
    apb(0, 8'h0C, 32'd0, 1);
    apb(0, 8'h0C, 32'd0, 0);
    apb(0, 8'h10, 32'd0, 0);
    apb(0, 8'h14, 32'd0, 0);

    // Overflow wrap
    apb(1, 8'h00, 32'hFFFF_FFFF, 0);
    apb(1, 8'h04, 32'h0000_0002, 0);
    apb(1, 8'h08, 32'h0000_0001, 0);
    idle(3);
    apb(0, 8'h10, 32'd0, 0);

    // Wait-state reads of RESULT (2 waits back-to-back, 1 wait with setup)
    apb(1, 8'h00, 32'h1111_0000, 0);
    apb(1, 8'h08, 32'h0000_0001, 0);
    apb(0, 8'h10, 32'd0, 1);
    apb(1, 8'h08, 32'h0000_0001, 0);
    apb(0, 8'h10, 32'd0, 0);

    // Busy protection
    apb(1, 8'h08, 32'h0000_0001, 0);
    apb(1, 8'h00, 32'h0000_1234, 1);
    apb(1, 8'h08, 32'h0000_0001, 1);
    apb(0, 8'h00, 32'd0, 0);
    apb(0, 8'h14, 32'd0, 0);

    // DONE_CLR accepted while busy; START+DONE_CLR together in idle
    apb(1, 8'h08, 32'h0000_0001, 0);
    apb(1, 8'h08, 32'h0000_0002, 1);
    apb(0, 8'h0C, 32'd0, 0);
    apb(1, 8'h08, 32'h0000_0003, 0);
    idle(3);
    apb(0, 8'h0C, 32'd0, 0);

    // IRQ follows DONE, cleared by DONE_CLR
    idle(2);
    apb(1, 8'h08, 32'h0000_0002, 0);
    apb(0, 8'h0C, 32'd0, 0);

    // Error addresses and writes to read-only registers
    apb(0, 8'h1C, 32'd0, 0);
    apb(1, 8'h1C, 32'hDEAD_BEEF, 0);
    apb(0, 8'hFC, 32'd0, 0);
    apb(1, 8'h0C, 32'hFFFF_FFFF, 0);
    apb(1, 8'h10, 32'hFFFF_FFFF, 0);
    apb(1, 8'h14, 32'hFFFF_FFFF, 0);
    apb(0, 8'h08, 32'd0, 0);

    // Counter sequence (narrow instance wraps at 4)
    for (int i = 0; i < 4; i++) begin
      apb(1, 8'h08, 32'h0000_0001, 0);
      idle(3);
      apb(0, 8'h14, 32'd0, 0);
    end

    // Reset during CAPT aborts the operation
    apb(1, 8'h08, 32'h0000_0001, 0);
    idle(1);
    rsn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_prdata", prdata, 32'd0);
    chk("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("mid_rst_pready", {31'd0, pready}, 32'd1);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_inA", ina, 32'd0);
    chk("mid_rst_inB", inb, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rsn = 1'b1;
    idle(2);
    apb(0, 8'h10, 32'd0, 0);
    apb(0, 8'h14, 32'd0, 0);
    apb(0, 8'h0C, 32'd0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (sel <= 5) a = {6'(sel), 2'($urandom_range(0, 3))};
      else if (sel == 6) a = 8'h1C;
      else if (sel == 7) a = {6'($urandom_range(6, 63)), 2'($urandom_range(0, 3))};
      else begin
        a = 8'h08;
        w = 1'b1;
        d = {$urandom_range(0, 1) == 0 ? 30'd0 : 30'($urandom), 2'($urandom_range(0, 3))};
      end
      apb(w, a, d, $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lab6_apb_slv_if.md
# lab6_apb_slv_if

APB slave interface stage directly upstream of the add/delay function block. It holds operands A and B in APB-writable registers and drives them to the function block. A start command launches a calculation. The block then captures the function block's registered sum, reports busy/done status and counts completed operations. RESULT reads issued while a calculation is in flight are stretched with APB wait states.

## Interface
- P_CNT_W, 16, width of the completed-operation counter (1..32)
- iClk  in  1  clock, rising edge
- iRsn  in  1  asynchronous, active-low reset
- iPsel  in  1  APB select
- iPenable  in  1  APB enable (access phase)
- iPwrite  in  1  APB write (1) / read (0)
- iPaddr  in  8  APB byte address; [1:0] ignored
- iPwdata  in  32  APB write data
- oPrdata  out  32  APB read data
- oPready  out  1  APB ready
- oPslverr  out  1  APB slave error
- oInA  out  32  operand A to function block
- oInB  out  32  operand B to function block
- iOutC  in  32  registered A+B from function block (1-clock latency)
- oIrq  out  1  done interrupt, level

Clock and reset are fixed: one clock, iClk, and reset iRsn, which is asynchronous and active-low.

## Operation
- Access is defined as iPsel & iPenable. A transfer completes on an access cycle with oPready=1.
- Register map:
  - 0x00 A: RW, 32 bits.
  - 0x04 B: RW, 32 bits.
  - 0x08 CTRL: W only, reads 0. bit0 START, bit1 DONE_CLR; write-1 pulses.
  - 0x0C STATUS: RO. bit0 BUSY, bit1 DONE.
  - 0x10 RESULT: RO, 32 bits.
  - 0x14 COUNT: RO, zero-extended P_CNT_W.
- Any other address completes with oPslverr=1. Reads of such an address return 0 and writes are dropped.
- oInA and oInB are the A and B registers, driven continuously.
- FSM states: IDLE, CALC, CAPT.
  - IDLE -> CALC on a completing write to CTRL with START=1. The same edge clears DONE.
  - CALC -> CAPT unconditionally. The function block latches A+B at this edge.
  - CAPT -> IDLE unconditionally. This edge sets RESULT <= iOutC, sets DONE=1 and increments COUNT.
- BUSY = (state != IDLE).
- While BUSY, the following complete with oPslverr=1 and have no effect: writes to A, writes to B, and a CTRL write with START=1.
- While BUSY, a CTRL write with DONE_CLR only is accepted.
- DONE_CLR=1 clears DONE. If START=1 and DONE_CLR=1 are written together in IDLE, the start is honoured.
- COUNT wraps from all-ones to 0.
- Arithmetic is performed by the function block and is modulo 2^32. RESULT stores iOutC unchanged.
- oPrdata is combinational. It equals the addressed register during a read access with oPready=1, and 0 otherwise.
- Writes to read-only registers (STATUS, RESULT, COUNT) complete with oPslverr=0 and are ignored.

## Timing
- Reset values, applied asynchronously while iRsn=0: state IDLE, A=0, B=0, RESULT=0, COUNT=0, DONE=0, oIrq=0, oPslverr=0, oPrdata=0.
- After reset, oPready=1.
- A reset asserted mid-operation aborts the operation with no capture. It is not counted.
- oPready=1 in every cycle, except a read access to RESULT while BUSY.
  - Such a read holds oPready=0 until the state returns to IDLE.
  - It then completes in the following cycle with the new RESULT.
  - Maximum wait is 2 cycles.
- oPslverr is valid only in the completing access cycle and is 0 otherwise.
- Latency: START write completes at edge t0. BUSY=1 in cycles t0+1 and t0+2. DONE, RESULT and COUNT update at edge t0+2. STATUS reads DONE=1 from cycle t0+3.
- The minimum start-to-start interval is 3 cycles.

## Configuration
- LAB6_APB_IRQ_EN defined: oIrq is a register.
  - Set at the DONE-setting edge.
  - Cleared by DONE_CLR or by the next START.
  - Follows DONE exactly.
- LAB6_APB_IRQ_EN undefined: oIrq is tied to 0 and no interrupt logic is built. DONE status is unaffected.

## Test plan
- Basic add: reset, write A=0x0000_0005, write B=0x0000_0007, write CTRL=0x1, poll STATUS.
  - Required: BUSY=1 for 2 cycles, then STATUS=0x2, RESULT=0x0000_000C, COUNT=1.
- Overflow wrap: A=0xFFFF_FFFF, B=0x0000_0002, START.
  - Required: RESULT=0x0000_0001, oPslverr=0 throughout.
- Wait-state read: START, then immediately read RESULT.
  - Required: oPready=0 for 2 cycles, read completes with A+B.
- Busy protection: during CALC, write A=0x1234 and a second START.
  - Required: both complete with oPslverr=1, A unchanged, COUNT increments by 1 only.
- Error and counter: read 0x1C.
  - Required: oPslverr=1, oPrdata=0.
  - Then with P_CNT_W=2, run 4 operations: COUNT reads 1, 2, 3, 0.
- IRQ and reset: with LAB6_APB_IRQ_EN defined, complete an operation, then write CTRL=0x2.
  - Required: oIrq rises with DONE and falls after the clear.
  - Then assert iRsn=0 during CAPT: all outputs go to reset values immediately and RESULT stays 0.
